// File: rtl/div_iter_ctrl_if.sv
// Request/response and shared-adder signals of the iterative divider controller.
// The master side issues requests and owns the carry-select adder; the slave side is the controller.
interface div_iter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  modport master (
    output start, op, dividend, divisor, add_sum, add_cout,
    input  busy, done, result, div_by_zero, add_a, add_b, add_cin
  );

  modport slave (
    input  start, op, dividend, divisor, add_sum, add_cout,
    output busy, done, result, div_by_zero, add_a, add_b, add_cin
  );
endinterface

// File: rtl/div_iter_ctrl.sv
// Restoring radix-2 divider controller: one quotient bit per cycle through an external adder,
// with sign fix-up for DIV/REM and a single-cycle bypass for a zero divisor.
module div_iter_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_iter_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] trial;
  logic             in_signed;
  logic             in_sign_a;
  logic             in_sign_b;

  assign trial     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign in_signed = ~bus.op[0];
  assign in_sign_a = in_signed & bus.dividend[WIDTH-1];
  assign in_sign_b = in_signed & bus.divisor[WIDTH-1];

  // NOTE: every always_comb output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    op_d        = op_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          q_d      = in_sign_a ? -bus.dividend : bus.dividend;
          d_d      = in_sign_b ? -bus.divisor  : bus.divisor;
          r_d      = '0;
          cnt_d    = '0;
          dbz_d    = (bus.divisor == '0);
          if (bus.divisor == '0) begin
            // Remainder ops report the untouched dividend, quotient ops all ones.
            result_d = bus.op[1] ? bus.dividend : '1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        bus.add_a   = trial;
        bus.add_b   = ~d_q;
        bus.add_cin = 1'b1;
        // r_q[WIDTH-1] is the bit shifted out of trial: when set, trial really exceeds D.
        if (r_q[WIDTH-1] | bus.add_cout) begin
          r_d = bus.add_sum;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (op_q[1]) begin
          result_d = sign_a_q ? -r_q : r_q;
        end else begin
          result_d = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_iter_ctrl.sv
// Bench for div_iter_ctrl: table of directed vectors plus a few random ones, scoreboarded results,
// and hand-written sequences for start-while-busy and reset during iteration.
module tb_div_iter_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT_NORMAL = WIDTH + 2;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dbz;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];
  exp_t sb[$];

  div_iter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_iter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared adder model living outside the controller.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sbv);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sbv);
      default: return a % b;
    endcase
  endfunction

  function automatic void add_vec(input string n, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] r, input logic dbz);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_dbz = dbz;
    vecs.push_back(v);
  endfunction

  // Drives one request at the current negedge and waits (bounded) for done.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got_e;
    int   n;
    bit   got;
    bit   busy_ok;
    e.name = v.name;
    e.res  = v.exp_res;
    e.dbz  = v.exp_dbz;
    e.lat  = (v.b == 32'd0) ? 1 : LAT_NORMAL;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.op       = v.op;
    bus.dividend = v.a;
    bus.divisor  = v.b;
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 100) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) begin
      check({v.name, " timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      got_e = sb.pop_front();
      check({got_e.name, " result"}, bus.result, got_e.res);
      check({got_e.name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, got_e.dbz});
      check({got_e.name, " latency"}, n, got_e.lat);
      check({got_e.name, " busy"}, {31'd0, busy_ok}, 32'd1);
    end
    @(negedge clk);
    check({v.name, " idle after done"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("reset adder", bus.add_a | bus.add_b | {31'd0, bus.add_cin}, 32'd0);
    // start while in reset must not launch anything
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(negedge clk);
    check("start under reset", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    add_vec("divu_100_7",   2'b01, 32'd100,       32'd7,         32'd14,          1'b0);
    add_vec("remu_100_7",   2'b11, 32'd100,       32'd7,         32'd2,           1'b0);
    add_vec("div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD,   1'b0);
    add_vec("rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF,   1'b0);
    add_vec("rem_7_m2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,           1'b0);
    add_vec("div_7_m2",     2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD,   1'b0);
    add_vec("divu_5_0",     2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF,   1'b1);
    add_vec("remu_5_0",     2'b11, 32'd5,         32'd0,         32'd5,           1'b1);
    add_vec("rem_m5_0",     2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB,   1'b1);
    add_vec("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,   1'b0);
    add_vec("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,           1'b0);
    add_vec("divu_max_1",   2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,   1'b0);
    add_vec("divu_max_msb", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,           1'b0);
    add_vec("remu_max_msb", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,   1'b0);
    add_vec("div_m0x_m1",   2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'd256,         1'b0);
    add_vec("divu_small",   2'b01, 32'd3,         32'd10,        32'd0,           1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      add_vec($sformatf("rand%0d", i), op, a, b, model(op, a, b), 1'b0);
    end
    foreach (vecs[i]) run_vec(vecs[i]);

    // start pulsed during busy is ignored
    begin
      int n;
      bit got;
      exp_t e;
      e.name = "busy_start"; e.res = 32'd14; e.dbz = 1'b0; e.lat = LAT_NORMAL;
      sb.push_back(e);
      bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7;
      n = 0; got = 0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (n == 5) begin
          bus.start = 1'b1; bus.op = 2'b00; bus.dividend = 32'd200; bus.divisor = 32'd0;
        end else begin
          bus.start = 1'b0;
        end
        if (n == 3) check("calc add_cin", {31'd0, bus.add_cin}, 32'd1);
        if (bus.done === 1'b1) got = 1;
      end
      if (!got) begin
        check("busy_start timeout", 32'd0, 32'd1);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        check("busy_start result", bus.result, e.res);
        check("busy_start dbz", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        check("busy_start latency", n, e.lat);
      end
      repeat (3) begin
        @(negedge clk);
        check("busy_start no relaunch", {31'd0, bus.busy}, 32'd0);
      end
      check("busy_start result held", bus.result, 32'd14);
      check("idle adder zero", bus.add_a | bus.add_b | {31'd0, bus.add_cin}, 32'd0);
    end

    // reset during CALC aborts the operation without a done pulse
    begin
      int dones;
      bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done === 1'b1) check("abort early done", 32'd1, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort result cleared", bus.result, 32'd0);
      check("abort dbz cleared", {31'd0, bus.div_by_zero}, 32'd0);
      dones = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      check("abort no done", dones, 32'd0);
    end

    check("scoreboard empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
